// File: rtl/axi_lite_pkg.sv
// Shared types and constants for the single-outstanding AXI4-Lite master core.
// Holds the FSM encoding, AXI response codes and host status bit positions.
package axi_lite_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    localparam logic [2:0] AXI_SIZE_32 = 3'b010;

    localparam int STATUS_RESP_LSB    = 0;
    localparam int STATUS_RESP_MSB    = 1;
    localparam int STATUS_TIMEOUT_BIT = 2;
    localparam int STATUS_BUSY_BIT    = 3;

    // Anything other than OKAY is reported to the host as an error, EXOKAY included.
    function automatic logic resp_is_error(input logic [1:0] resp);
        logic err;
        case (resp)
            AXI_RESP_OKAY:   err = 1'b0;
            AXI_RESP_EXOKAY: err = 1'b1;
            AXI_RESP_SLVERR: err = 1'b1;
            AXI_RESP_DECERR: err = 1'b1;
            default:         err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/axi_lite_master_core.sv
// Converts a level-based host command into one 32-bit AXI4-Lite transaction,
// with a per-transaction timeout and a registered interrupt summary.
module axi_lite_master_core
    import axi_lite_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned INTERRUPT_WIDTH = 32,
    parameter int unsigned DEFAULT_TIMEOUT = 100000000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_cmd_en,
    output logic                       o_cmd_error,
    output logic                       o_cmd_ack,
    output logic [31:0]                o_cmd_status,
    input  logic [ADDR_WIDTH-1:0]      i_cmd_addr,
    input  logic                       i_cmd_wr_rd,
    input  logic [3:0]                 i_cmd_byte_en,
    input  logic [31:0]                i_cmd_data,
    output logic [31:0]                o_cmd_data,
    output logic                       o_cmd_interrupt,
    output logic [3:0]                 o_awid,
    output logic [ADDR_WIDTH-1:0]      o_awaddr,
    output logic [2:0]                 o_awsize,
    output logic                       o_awvalid,
    input  logic                       i_awready,
    output logic [3:0]                 o_wid,
    output logic [31:0]                o_wdata,
    output logic [3:0]                 o_wstrobe,
    output logic                       o_wlast,
    output logic                       o_wvalid,
    input  logic                       i_wready,
    input  logic [3:0]                 i_bid,
    input  logic [1:0]                 i_bresp,
    input  logic                       i_bvalid,
    output logic                       o_bready,
    output logic [3:0]                 o_arid,
    output logic [ADDR_WIDTH-1:0]      o_araddr,
    output logic [7:0]                 o_arlen,
    output logic [2:0]                 o_arsize,
    output logic                       o_arvalid,
    input  logic                       i_arready,
    input  logic [3:0]                 i_rid,
    input  logic [31:0]                i_rdata,
    input  logic [3:0]                 i_rstrobe,
    input  logic                       i_rlast,
    input  logic [1:0]                 i_rresp,
    input  logic                       i_rvalid,
    output logic                       o_rready,
    input  logic [INTERRUPT_WIDTH-1:0] i_interrupts
);

    localparam logic [31:0] TIMEOUT_LAST = 32'(DEFAULT_TIMEOUT - 32'd1);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [3:0]              wstrb_q, wstrb_d;
    logic [31:0]             rdata_q, rdata_d;
    logic [31:0]             cnt_q, cnt_d;
    logic [1:0]              resp_q, resp_d;
    logic                    awvalid_q, awvalid_d;
    logic                    wvalid_q, wvalid_d;
    logic                    arvalid_q, arvalid_d;
    logic                    bready_q, bready_d;
    logic                    rready_q, rready_d;
    logic                    ack_q, ack_d;
    logic                    error_q, error_d;
    logic                    timeout_q, timeout_d;
    logic                    busy_q, busy_d;
    logic                    irq_q, irq_d;
    logic                    timeout_hit_s;
    logic [31:0]             status_s;
    logic                    unused_s;

    assign unused_s = ^{i_bid, i_rid, i_rstrobe, i_rlast};

    // Next-state and next-output logic for the transaction FSM.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;
        resp_d    = resp_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        bready_d  = bready_q;
        rready_d  = rready_q;
        ack_d     = ack_q;
        error_d   = error_q;
        timeout_d = timeout_q;
        busy_d    = busy_q;
        irq_d     = |i_interrupts;

        timeout_hit_s = (state_q inside {ST_WR, ST_WR_RESP, ST_RD_ADDR, ST_RD_DATA})
                        && (cnt_q == TIMEOUT_LAST);

        if (timeout_hit_s) begin
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            arvalid_d = 1'b0;
            bready_d  = 1'b0;
            rready_d  = 1'b0;
            timeout_d = 1'b1;
            error_d   = 1'b1;
            busy_d    = 1'b0;
            state_d   = ST_DONE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // The ack check stops a still-high enable from re-launching a finished command.
                    if (i_cmd_en && !ack_q) begin
                        addr_d    = i_cmd_addr;
                        wdata_d   = i_cmd_data;
                        wstrb_d   = i_cmd_byte_en;
                        error_d   = 1'b0;
                        resp_d    = AXI_RESP_OKAY;
                        timeout_d = 1'b0;
                        busy_d    = 1'b1;
                        cnt_d     = 32'd0;
                        if (i_cmd_wr_rd) begin
                            awvalid_d = 1'b1;
                            wvalid_d  = 1'b1;
                            state_d   = ST_WR;
                        end else begin
                            arvalid_d = 1'b1;
                            state_d   = ST_RD_ADDR;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_WR: begin
                    cnt_d     = cnt_q + 32'd1;
                    awvalid_d = awvalid_q && !i_awready;
                    wvalid_d  = wvalid_q && !i_wready;
                    if ((!awvalid_q || i_awready) && (!wvalid_q || i_wready)) begin
                        bready_d = 1'b1;
                        state_d  = ST_WR_RESP;
                    end else begin
                        state_d = ST_WR;
                    end
                end
                ST_WR_RESP: begin
                    cnt_d = cnt_q + 32'd1;
                    if (i_bvalid) begin
                        bready_d = 1'b0;
                        resp_d   = i_bresp;
                        error_d  = resp_is_error(i_bresp);
                        busy_d   = 1'b0;
                        state_d  = ST_DONE;
                    end else begin
                        state_d = ST_WR_RESP;
                    end
                end
                ST_RD_ADDR: begin
                    cnt_d = cnt_q + 32'd1;
                    if (i_arready) begin
                        arvalid_d = 1'b0;
                        rready_d  = 1'b1;
                        state_d   = ST_RD_DATA;
                    end else begin
                        state_d = ST_RD_ADDR;
                    end
                end
                ST_RD_DATA: begin
                    cnt_d = cnt_q + 32'd1;
                    if (i_rvalid) begin
                        rready_d = 1'b0;
                        rdata_d  = i_rdata;
                        resp_d   = i_rresp;
                        error_d  = resp_is_error(i_rresp);
                        busy_d   = 1'b0;
                        state_d  = ST_DONE;
                    end else begin
                        state_d = ST_RD_DATA;
                    end
                end
                ST_DONE: begin
                    if (ack_q && !i_cmd_en) begin
                        ack_d   = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        ack_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
                default: begin
                    awvalid_d = 1'b0;
                    wvalid_d  = 1'b0;
                    arvalid_d = 1'b0;
                    bready_d  = 1'b0;
                    rready_d  = 1'b0;
                    ack_d     = 1'b0;
                    busy_d    = 1'b0;
                    state_d   = ST_IDLE;
                end
            endcase
        end
    end

    // State, channel and host-side registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            wdata_q   <= 32'd0;
            wstrb_q   <= 4'd0;
            rdata_q   <= 32'd0;
            cnt_q     <= 32'd0;
            resp_q    <= 2'd0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            bready_q  <= 1'b0;
            rready_q  <= 1'b0;
            ack_q     <= 1'b0;
            error_q   <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            cnt_q     <= cnt_d;
            resp_q    <= resp_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            bready_q  <= bready_d;
            rready_q  <= rready_d;
            ack_q     <= ack_d;
            error_q   <= error_d;
            timeout_q <= timeout_d;
            busy_q    <= busy_d;
            irq_q     <= irq_d;
        end
    end

    // Host status word assembled from the individual status flops.
    always_comb begin
        status_s = 32'd0;
        status_s[STATUS_RESP_MSB:STATUS_RESP_LSB] = resp_q;
        status_s[STATUS_TIMEOUT_BIT]              = timeout_q;
        status_s[STATUS_BUSY_BIT]                 = busy_q;
    end

    assign o_cmd_status    = status_s;
    assign o_cmd_error     = error_q;
    assign o_cmd_ack       = ack_q;
    assign o_cmd_data      = rdata_q;
    assign o_cmd_interrupt = irq_q;

    assign o_awid    = 4'd0;
    assign o_wid     = 4'd0;
    assign o_arid    = 4'd0;
    assign o_awsize  = AXI_SIZE_32;
    assign o_arsize  = AXI_SIZE_32;
    assign o_arlen   = 8'd0;
    assign o_awaddr  = addr_q;
    assign o_araddr  = addr_q;
    assign o_awvalid = awvalid_q;
    assign o_wvalid  = wvalid_q;
    assign o_wlast   = wvalid_q;
    assign o_wdata   = wdata_q;
    assign o_wstrobe = wstrb_q;
    assign o_arvalid = arvalid_q;
    assign o_bready  = bready_q;
    assign o_rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_master_core.sv
// Directed bench for axi_lite_master_core: hand-timed slave responses with
// inline expected values; timeout shortened to 16 cycles.
module tb_axi_lite_master_core;

    logic        clk;
    logic        rst;
    logic        i_cmd_en;
    logic        o_cmd_error;
    logic        o_cmd_ack;
    logic [31:0] o_cmd_status;
    logic [31:0] i_cmd_addr;
    logic        i_cmd_wr_rd;
    logic [3:0]  i_cmd_byte_en;
    logic [31:0] i_cmd_data;
    logic [31:0] o_cmd_data;
    logic        o_cmd_interrupt;
    logic [3:0]  o_awid, o_wid, o_arid;
    logic [31:0] o_awaddr, o_araddr;
    logic [2:0]  o_awsize, o_arsize;
    logic [7:0]  o_arlen;
    logic        o_awvalid, o_wvalid, o_arvalid;
    logic        i_awready, i_wready, i_arready;
    logic [31:0] o_wdata;
    logic [3:0]  o_wstrobe;
    logic        o_wlast;
    logic [3:0]  i_bid;
    logic [1:0]  i_bresp;
    logic        i_bvalid;
    logic        o_bready;
    logic [3:0]  i_rid;
    logic [31:0] i_rdata;
    logic [1:0]  i_rresp;
    logic [3:0]  i_rstrobe;
    logic        i_rlast;
    logic        i_rvalid;
    logic        o_rready;
    logic [31:0] i_interrupts;

    int n_cmp;
    int n_fail;

    axi_lite_master_core #(
        .ADDR_WIDTH(32), .INTERRUPT_WIDTH(32), .DEFAULT_TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst),
        .i_cmd_en(i_cmd_en), .o_cmd_error(o_cmd_error), .o_cmd_ack(o_cmd_ack),
        .o_cmd_status(o_cmd_status), .i_cmd_addr(i_cmd_addr), .i_cmd_wr_rd(i_cmd_wr_rd),
        .i_cmd_byte_en(i_cmd_byte_en), .i_cmd_data(i_cmd_data), .o_cmd_data(o_cmd_data),
        .o_cmd_interrupt(o_cmd_interrupt),
        .o_awid(o_awid), .o_awaddr(o_awaddr), .o_awsize(o_awsize), .o_awvalid(o_awvalid),
        .i_awready(i_awready),
        .o_wid(o_wid), .o_wdata(o_wdata), .o_wstrobe(o_wstrobe), .o_wlast(o_wlast),
        .o_wvalid(o_wvalid), .i_wready(i_wready),
        .i_bid(i_bid), .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready),
        .o_arid(o_arid), .o_araddr(o_araddr), .o_arlen(o_arlen), .o_arsize(o_arsize),
        .o_arvalid(o_arvalid), .i_arready(i_arready),
        .i_rid(i_rid), .i_rdata(i_rdata), .i_rstrobe(i_rstrobe), .i_rlast(i_rlast),
        .i_rresp(i_rresp), .i_rvalid(i_rvalid), .o_rready(o_rready),
        .i_interrupts(i_interrupts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic slave(input logic aw, input logic w, input logic b, input logic ar, input logic r);
        i_awready = aw; i_wready = w; i_bvalid = b; i_arready = ar; i_rvalid = r;
    endtask

    task automatic cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
        i_cmd_wr_rd = wr; i_cmd_addr = addr; i_cmd_data = data; i_cmd_byte_en = be; i_cmd_en = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({o_awvalid, o_wvalid, o_arvalid, o_bready, o_rready, o_cmd_ack, o_cmd_error, o_cmd_interrupt} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 00000000",
                     {o_awvalid, o_wvalid, o_arvalid, o_bready, o_rready, o_cmd_ack, o_cmd_error, o_cmd_interrupt});
        end
        n_cmp++;
        if ({o_cmd_status, o_cmd_data, o_awaddr, o_wdata} !== 128'd0) begin
            n_fail++;
            $display("FAIL reset_data: got status=%h data=%h awaddr=%h wdata=%h want all 0",
                     o_cmd_status, o_cmd_data, o_awaddr, o_wdata);
        end
        n_cmp++;
        if ({o_awid, o_wid, o_arid, o_awsize, o_arsize, o_arlen} !== {4'd0, 4'd0, 4'd0, 3'b010, 3'b010, 8'd0}) begin
            n_fail++;
            $display("FAIL reset_const: got ids=%h/%h/%h sizes=%b/%b arlen=%h want 0/0/0 010/010 00",
                     o_awid, o_wid, o_arid, o_awsize, o_arsize, o_arlen);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_write;
        slave(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        i_bresp = 2'b00;
        cmd(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF);
        tick();
        n_cmp++;
        if ({o_awvalid, o_wvalid, o_wlast, o_wstrobe, o_awaddr, o_wdata, o_cmd_status} !==
            {1'b1, 1'b1, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF, 32'h8}) begin
            n_fail++;
            $display("FAIL wr_beat: got aw=%b w=%b last=%b strb=%h addr=%h data=%h st=%h want 1 1 1 f 10 deadbeef 8",
                     o_awvalid, o_wvalid, o_wlast, o_wstrobe, o_awaddr, o_wdata, o_cmd_status);
        end
        tick();
        n_cmp++;
        if ({o_awvalid, o_wvalid, o_bready} !== 3'b001) begin
            n_fail++;
            $display("FAIL wr_bready: got aw/w/b=%b want 001", {o_awvalid, o_wvalid, o_bready});
        end
        tick();
        n_cmp++;
        if ({o_cmd_ack, o_bready} !== 2'b00) begin
            n_fail++;
            $display("FAIL wr_latency3: got ack/bready=%b want 00", {o_cmd_ack, o_bready});
        end
        tick();
        n_cmp++;
        if ({o_cmd_ack, o_cmd_error, o_cmd_status} !== {1'b1, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL wr_ack: got ack=%b err=%b st=%h want 1 0 0", o_cmd_ack, o_cmd_error, o_cmd_status);
        end
        i_cmd_en = 1'b0;
        slave(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        n_cmp++;
        if (o_cmd_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_ack_release: got %b want 0", o_cmd_ack);
        end
    endtask

    task automatic test_read_delay;
        slave(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cmd(1'b0, 32'h0000_0020, 32'h0, 4'h0);
        tick();
        n_cmp++;
        if ({o_arvalid, o_araddr, o_arlen, o_arsize} !== {1'b1, 32'h20, 8'd0, 3'b010}) begin
            n_fail++;
            $display("FAIL rd_addr: got arvalid=%b araddr=%h len=%h size=%b want 1 20 00 010",
                     o_arvalid, o_araddr, o_arlen, o_arsize);
        end
        tick();
        n_cmp++;
        if ({o_arvalid, o_rready} !== 2'b01) begin
            n_fail++;
            $display("FAIL rd_rready: got arvalid/rready=%b want 01", {o_arvalid, o_rready});
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({o_rready, o_cmd_ack} !== 2'b10) begin
                n_fail++;
                $display("FAIL rd_wait%0d: got rready/ack=%b want 10", i, {o_rready, o_cmd_ack});
            end
        end
        i_rvalid = 1'b1; i_rdata = 32'h1234_5678; i_rresp = 2'b00;
        tick();
        i_rvalid = 1'b0; i_rdata = 32'h0;
        n_cmp++;
        if ({o_rready, o_cmd_ack} !== 2'b00) begin
            n_fail++;
            $display("FAIL rd_done: got rready/ack=%b want 00", {o_rready, o_cmd_ack});
        end
        tick();
        n_cmp++;
        if ({o_cmd_ack, o_cmd_error, o_cmd_data, o_cmd_status} !== {1'b1, 1'b0, 32'h1234_5678, 32'h0}) begin
            n_fail++;
            $display("FAIL rd_result: got ack=%b err=%b data=%h st=%h want 1 0 12345678 0",
                     o_cmd_ack, o_cmd_error, o_cmd_data, o_cmd_status);
        end
        i_cmd_en = 1'b0;
        slave(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_aw_late;
        slave(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cmd(1'b1, 32'h0000_0044, 32'hA5A5_0F0F, 4'h3);
        tick();
        n_cmp++;
        if ({o_awvalid, o_wvalid, o_wstrobe} !== {1'b1, 1'b1, 4'h3}) begin
            n_fail++;
            $display("FAIL awl_start: got aw/w=%b strb=%h want 11 3", {o_awvalid, o_wvalid}, o_wstrobe);
        end
        tick();
        n_cmp++;
        if ({o_awvalid, o_wvalid} !== 2'b10) begin
            n_fail++;
            $display("FAIL awl_wdrop: got aw/w=%b want 10", {o_awvalid, o_wvalid});
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if ({o_awvalid, o_wvalid, o_bready} !== 3'b100) begin
                n_fail++;
                $display("FAIL awl_hold%0d: got aw/w/b=%b want 100", i, {o_awvalid, o_wvalid, o_bready});
            end
        end
        i_awready = 1'b1;
        tick();
        i_awready = 1'b0;
        n_cmp++;
        if ({o_awvalid, o_bready} !== 2'b01) begin
            n_fail++;
            $display("FAIL awl_awdone: got aw/bready=%b want 01", {o_awvalid, o_bready});
        end
        i_bvalid = 1'b1; i_bresp = 2'b00;
        tick();
        i_bvalid = 1'b0;
        tick();
        n_cmp++;
        if ({o_cmd_ack, o_cmd_error, o_cmd_status} !== {1'b1, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL awl_ack: got ack=%b err=%b st=%h want 1 0 0", o_cmd_ack, o_cmd_error, o_cmd_status);
        end
        i_cmd_en = 1'b0;
        slave(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({o_cmd_ack, o_awvalid, o_wvalid, o_arvalid, o_bready} !== 5'b00000) begin
                n_fail++;
                $display("FAIL awl_idle%0d: got %b want 00000", i,
                         {o_cmd_ack, o_awvalid, o_wvalid, o_arvalid, o_bready});
            end
        end
    endtask

    task automatic test_read_error;
        slave(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        i_rresp = 2'b10; i_rdata = 32'hCAFE_0001;
        cmd(1'b0, 32'h0000_0030, 32'h0, 4'h0);
        repeat (4) tick();
        n_cmp++;
        if ({o_cmd_ack, o_cmd_error, o_cmd_status, o_cmd_data} !== {1'b1, 1'b1, 32'h2, 32'hCAFE_0001}) begin
            n_fail++;
            $display("FAIL rderr_result: got ack=%b err=%b st=%h data=%h want 1 1 2 cafe0001",
                     o_cmd_ack, o_cmd_error, o_cmd_status, o_cmd_data);
        end
        slave(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        i_rresp = 2'b00;
        i_cmd_en = 1'b0;
        tick();
        n_cmp++;
        if ({o_cmd_ack, o_cmd_error, o_cmd_status} !== {1'b0, 1'b1, 32'h2}) begin
            n_fail++;
            $display("FAIL rderr_hold: got ack=%b err=%b st=%h want 0 1 2", o_cmd_ack, o_cmd_error, o_cmd_status);
        end
        slave(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        i_bresp = 2'b00;
        cmd(1'b1, 32'h0000_0034, 32'h5555_AAAA, 4'hF);
        tick();
        n_cmp++;
        if ({o_cmd_error, o_cmd_status} !== {1'b0, 32'h8}) begin
            n_fail++;
            $display("FAIL rderr_clear: got err=%b st=%h want 0 8", o_cmd_error, o_cmd_status);
        end
        repeat (3) tick();
        n_cmp++;
        if ({o_cmd_ack, o_cmd_error, o_cmd_status} !== {1'b1, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL rderr_next: got ack=%b err=%b st=%h want 1 0 0", o_cmd_ack, o_cmd_error, o_cmd_status);
        end
        i_cmd_en = 1'b0;
        slave(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_timeout;
        slave(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cmd(1'b1, 32'h0000_0080, 32'h1111_2222, 4'hF);
        tick();
        for (int i = 1; i < 16; i++) begin
            tick();
            n_cmp++;
            if ({o_awvalid, o_wvalid} !== 2'b11) begin
                n_fail++;
                $display("FAIL to_hold%0d: got aw/w=%b want 11", i, {o_awvalid, o_wvalid});
            end
        end
        tick();
        n_cmp++;
        if ({o_awvalid, o_wvalid, o_bready, o_cmd_ack, o_cmd_status} !== {4'b0000, 32'h4}) begin
            n_fail++;
            $display("FAIL to_abort: got aw/w/b/ack=%b st=%h want 0000 4",
                     {o_awvalid, o_wvalid, o_bready, o_cmd_ack}, o_cmd_status);
        end
        tick();
        n_cmp++;
        if ({o_cmd_ack, o_cmd_error, o_cmd_status} !== {1'b1, 1'b1, 32'h4}) begin
            n_fail++;
            $display("FAIL to_ack: got ack=%b err=%b st=%h want 1 1 4", o_cmd_ack, o_cmd_error, o_cmd_status);
        end
        i_cmd_en = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid;
        int cycles;
        slave(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cmd(1'b1, 32'h0000_0055, 32'h7777_8888, 4'hF);
        tick();
        tick();
        #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({o_awvalid, o_wvalid, o_cmd_ack, o_cmd_error, o_awaddr, o_cmd_status} !== {4'b0000, 32'h0, 32'h0}) begin
            n_fail++;
            $display("FAIL rstmid_drop: got aw/w/ack/err=%b addr=%h st=%h want 0000 0 0",
                     {o_awvalid, o_wvalid, o_cmd_ack, o_cmd_error}, o_awaddr, o_cmd_status);
        end
        i_cmd_en = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        tick();
        slave(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        i_bresp = 2'b00;
        cmd(1'b1, 32'h0000_0060, 32'h0102_0304, 4'hF);
        cycles = 0;
        while (o_cmd_ack !== 1'b1 && cycles < 10) begin
            tick();
            cycles++;
        end
        n_cmp++;
        if ({o_cmd_ack, o_cmd_error, o_cmd_status, o_awaddr} !== {1'b1, 1'b0, 32'h0, 32'h60} || cycles != 4) begin
            n_fail++;
            $display("FAIL rstmid_recover: got ack=%b err=%b st=%h addr=%h after %0d cycles want 1 0 0 60 after 4",
                     o_cmd_ack, o_cmd_error, o_cmd_status, o_awaddr, cycles);
        end
        i_cmd_en = 1'b0;
        slave(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
    endtask

    task automatic test_interrupt;
        i_interrupts = 32'h8000_0000;
        tick();
        n_cmp++;
        if (o_cmd_interrupt !== 1'b1) begin
            n_fail++;
            $display("FAIL irq_set: got %b want 1", o_cmd_interrupt);
        end
        i_interrupts = 32'h0;
        tick();
        n_cmp++;
        if (o_cmd_interrupt !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_clear: got %b want 0", o_cmd_interrupt);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst = 1'b0;
        i_cmd_en = 1'b0; i_cmd_addr = 32'h0; i_cmd_wr_rd = 1'b0; i_cmd_byte_en = 4'h0; i_cmd_data = 32'h0;
        i_awready = 1'b0; i_wready = 1'b0; i_arready = 1'b0;
        i_bid = 4'h0; i_bresp = 2'b00; i_bvalid = 1'b0;
        i_rid = 4'h0; i_rdata = 32'h0; i_rresp = 2'b00; i_rstrobe = 4'h0; i_rlast = 1'b0; i_rvalid = 1'b0;
        i_interrupts = 32'h0;
        test_reset();
        test_write();
        test_read_delay();
        test_aw_late();
        test_read_error();
        test_timeout();
        test_reset_mid();
        test_interrupt();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
